hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and flush controller for the 5-stage pipeline. Produces the `controlZeroIdEx` bubble request and the PC and IF/ID hold/flush controls consumed by the pipeline registers.
- Keeps a 3-slot shadow pipeline (EX/MEM/WB) of in-flight register writers. Compares the decode-stage source registers against it to detect RAW hazards.
- Handles taken-branch/jump flushes and halt drain. Keeps saturating stall/flush counters.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- RsId  in  3  decode-stage source register Rs.
- RtId  in  3  decode-stage source register Rt.
- RsValidId  in  1  Rs is actually read.
- RtValidId  in  1  Rt is actually read.
- writeRegId  in  3  decode-stage destination register.
- writeRegValidId  in  1  destination field is meaningful.
- RegWriteId  in  1  decode instruction writes the register file.
- MemReadId  in  1  decode instruction is a load.
- haltId  in  1  decode instruction is HALT.
- redirectEx  in  1  taken branch or jump resolved in EX this cycle.
- controlZeroIdEx  out  1  insert bubble into ID/EX.
- stallPc  out  1  hold PC.
- stallIfId  out  1  hold IF/ID.
- flushIfId  out  1  zero IF/ID.
- halted  out  1  FSM in HALTED.
- stallCnt  out  CNT_W  cycles spent in hazard stall, saturating.
- flushCnt  out  CNT_W  redirect events, saturating.

Behaviour:
- Reset (async, active-high):
  - All shadow slots invalid; FSM = RUN; both counters = 0.
  - All combinational outputs evaluate to 0.
- Shadow slot contents: {v, reg[2:0], ld}.
- Slot update each posedge:
  - WB <= MEM; MEM <= EX.
  - EX <= {issue & RegWriteId & writeRegValidId, writeRegId, MemReadId}.
  - issue = ~controlZeroIdEx (a bubble or flush records an empty EX slot).
- Source match: srcHit(slot) = slot.v & ((RsValidId & RsId==slot.reg) | (RtValidId & RtId==slot.reg)).
- Hazard (no forwarding): hz = srcHit(EX) | srcHit(MEM) | srcHit(WB).
- FSM states and outputs:
  - RUN:
    - If redirectEx: flushIfId=1, controlZeroIdEx=1, stallPc=0, stallIfId=0. Flush wins over hazard and halt; the younger ID instruction is discarded.
    - Else if hz: controlZeroIdEx=1, stallPc=1, stallIfId=1; stay RUN.
    - Else if haltId: instruction issues normally; next state HALTED.
    - Else all outputs 0.
  - HALTED:
    - controlZeroIdEx=1, stallPc=1, stallIfId=1, halted=1.
    - redirectEx ignored; slots keep draining.
    - Leaves only on rst.
- Counters:
  - stallCnt += 1 on each RUN cycle with hz & ~redirectEx.
  - flushCnt += 1 on each RUN cycle with redirectEx.
  - Both hold at all-ones (no wrap).
- Simultaneous events: redirectEx with hz → flush only, stallCnt unchanged. redirectEx with haltId → halt discarded, stays RUN.
- Stall release: occurs the cycle the matching writer leaves the compared slots; no extra cycle.
- Reset mid-stall: outputs drop immediately; slots cleared.
- r0 is an ordinary register (no hardwired-zero exemption).

Optional Feature:
- Macro: HAZARD_FORWARD_EN.
- Defined (EX/MEM forwarding present):
  - hz = srcHit(EX) & EX.ld, i.e. load-use only.
  - Stall is exactly 1 cycle, because the next cycle the load sits in MEM and forwarding covers it.
- Undefined: full hazard check across EX, MEM and WB as above (up to 3-cycle stall).

Test Plan:
- Reset with rst pulsed asynchronously mid-cycle → all outputs 0 immediately; stallCnt=0, flushCnt=0; slots empty (a following dependent instruction does not stall).
- No forwarding: ADD r3 issued, then dependent instruction with RsId=3, RsValidId=1 → controlZeroIdEx/stallPc/stallIfId high 3 consecutive cycles, low on 4th; stallCnt=3.
- HAZARD_FORWARD_EN: LD r2, then RtId=2, RtValidId=1 → exactly 1 stall cycle. Same sequence with non-load writer → 0 stall cycles.
- redirectEx=1 while hz is true → flushIfId=1, controlZeroIdEx=1, stallPc=0; flushCnt 0→1; stallCnt unchanged; EX slot invalid next cycle.
- haltId=1 with no hazard → next cycle halted=1, stallPc=1, controlZeroIdEx=1 held for 10+ cycles; redirectEx pulse ignored. haltId with redirectEx same cycle → halted stays 0.
- Force 65 540 hazard cycles (CNT_W=16) → stallCnt saturates at 0xFFFF, no wrap.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : RAW hazard, branch flush and halt-drain control for the 5-stage
//               pipeline. Optional EX/MEM forwarding: `define HAZARD_FORWARD_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       RsId,
  input  logic [2:0]       RtId,
  input  logic             RsValidId,
  input  logic             RtValidId,
  input  logic [2:0]       writeRegId,
  input  logic             writeRegValidId,
  input  logic             RegWriteId,
  input  logic             MemReadId,
  input  logic             haltId,
  input  logic             redirectEx,
  output logic             controlZeroIdEx,
  output logic             stallPc,
  output logic             stallIfId,
  output logic             flushIfId,
  output logic             halted,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);

  localparam logic [0:0] c_RUN    = 1'b0;
  localparam logic [0:0] c_HALTED = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_nextState;
  logic             r_exV, r_memV, r_wbV;
  logic [2:0]       r_exReg, r_memReg, r_wbReg;
  logic             r_exLd;
  logic [CNT_W-1:0] r_stallCnt, r_flushCnt;
  logic             w_exHit, w_memHit, w_wbHit, w_hz;
  logic             w_stallEv, w_flushEv;

  function automatic logic srcHit(input logic v, input logic [2:0] r,
                                  input logic [2:0] rs, input logic rsv,
                                  input logic [2:0] rt, input logic rtv);
    return v & ((rsv & (rs == r)) | (rtv & (rt == r)));
  endfunction

  assign w_exHit  = srcHit(r_exV,  r_exReg,  RsId, RsValidId, RtId, RtValidId);
  assign w_memHit = srcHit(r_memV, r_memReg, RsId, RsValidId, RtId, RtValidId);
  assign w_wbHit  = srcHit(r_wbV,  r_wbReg,  RsId, RsValidId, RtId, RtValidId);

`ifdef HAZARD_FORWARD_EN
  // Forwarding covers everything except a load still in EX.
  assign w_hz = w_exHit & r_exLd;
`else
  assign w_hz = w_exHit | w_memHit | w_wbHit;
`endif

  always_comb begin
    controlZeroIdEx = 1'b0;
    stallPc         = 1'b0;
    stallIfId       = 1'b0;
    flushIfId       = 1'b0;
    halted          = 1'b0;
    w_nextState     = r_state;
    if (!rst) begin
      if (r_state == c_HALTED) begin
        controlZeroIdEx = 1'b1;
        stallPc         = 1'b1;
        stallIfId       = 1'b1;
        halted          = 1'b1;
      end else if (redirectEx) begin
        flushIfId       = 1'b1;
        controlZeroIdEx = 1'b1;
      end else if (w_hz) begin
        controlZeroIdEx = 1'b1;
        stallPc         = 1'b1;
        stallIfId       = 1'b1;
      end else if (haltId) begin
        w_nextState = c_HALTED;
      end
    end
  end

  assign w_stallEv = (r_state == c_RUN) & w_hz & ~redirectEx;
  assign w_flushEv = (r_state == c_RUN) & redirectEx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_RUN;
      r_exV      <= 1'b0;
      r_memV     <= 1'b0;
      r_wbV      <= 1'b0;
      r_exReg    <= 3'd0;
      r_memReg   <= 3'd0;
      r_wbReg    <= 3'd0;
      r_exLd     <= 1'b0;
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      r_state  <= w_nextState;
      r_wbV    <= r_memV;
      r_wbReg  <= r_memReg;
      r_memV   <= r_exV;
      r_memReg <= r_exReg;
      // A bubbled or flushed ID instruction leaves an empty EX slot.
      r_exV    <= ~controlZeroIdEx & RegWriteId & writeRegValidId;
      r_exReg  <= writeRegId;
      r_exLd   <= MemReadId;
      if (w_stallEv && (r_stallCnt != {CNT_W{1'b1}}))
        r_stallCnt <= r_stallCnt + 1'b1;
      if (w_flushEv && (r_flushCnt != {CNT_W{1'b1}}))
        r_flushCnt <= r_flushCnt + 1'b1;
    end
  end

  assign stallCnt = r_stallCnt;
  assign flushCnt = r_flushCnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : scoreboard bench for hazard_ctrl (directed vectors).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int CNT_W = 16;
  localparam int c_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [2:0]       RsId = 3'd0, RtId = 3'd0, writeRegId = 3'd0;
  logic             RsValidId = 1'b0, RtValidId = 1'b0, writeRegValidId = 1'b0;
  logic             RegWriteId = 1'b0, MemReadId = 1'b0, haltId = 1'b0, redirectEx = 1'b0;
  logic             controlZeroIdEx, stallPc, stallIfId, flushIfId, halted;
  logic [CNT_W-1:0] stallCnt, flushCnt;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RsId(RsId), .RtId(RtId), .RsValidId(RsValidId), .RtValidId(RtValidId),
    .writeRegId(writeRegId), .writeRegValidId(writeRegValidId),
    .RegWriteId(RegWriteId), .MemReadId(MemReadId), .haltId(haltId),
    .redirectEx(redirectEx),
    .controlZeroIdEx(controlZeroIdEx), .stallPc(stallPc), .stallIfId(stallIfId),
    .flushIfId(flushIfId), .halted(halted),
    .stallCnt(stallCnt), .flushCnt(flushCnt)
  );

  always #5 clk = ~clk;

  // Expected output bits are {controlZeroIdEx, stallPc, stallIfId, flushIfId, halted}.
  typedef struct {
    string    nm;
    logic [4:0] eo;
    int       sc;
    int       fc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   expSc  = 0;
  int   expFc  = 0;

  localparam logic [4:0] c_IDLE  = 5'b00000;
  localparam logic [4:0] c_STALL = 5'b11100;
  localparam logic [4:0] c_FLUSH = 5'b10010;
  localparam logic [4:0] c_HALT  = 5'b11101;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [4:0] got;
      e   = q.pop_front();
      got = {controlZeroIdEx, stallPc, stallIfId, flushIfId, halted};
      checks++;
      if (got !== e.eo || stallCnt !== CNT_W'(e.sc) || flushCnt !== CNT_W'(e.fc)) begin
        errors++;
        $display("FAIL %s: got ctl=%b stallCnt=%0d flushCnt=%0d, want ctl=%b stallCnt=%0d flushCnt=%0d",
                 e.nm, got, stallCnt, flushCnt, e.eo, e.sc, e.fc);
      end
    end
  end

  task automatic cyc(input string nm,
                     input logic [2:0] rs, input logic rsv,
                     input logic [2:0] rt, input logic rtv,
                     input logic [2:0] wr, input logic wen, input logic ld,
                     input logic hlt, input logic rdr,
                     input logic [4:0] eo);
    @(posedge clk);
    #1;
    RsId = rs; RsValidId = rsv; RtId = rt; RtValidId = rtv;
    writeRegId = wr; writeRegValidId = wen; RegWriteId = wen; MemReadId = ld;
    haltId = hlt; redirectEx = rdr;
    q.push_back('{nm, eo, expSc, expFc});
    if (eo == c_STALL && expSc < c_MAX) expSc++;
    if (eo[1] && expFc < c_MAX) expFc++;
  endtask

  // Reset asserted between edges; outputs must drop before the next edge.
  task automatic pulseRst(input string nm);
    @(posedge clk);
    #2;
    rst = 1'b1;
    expSc = 0;
    expFc = 0;
    q.push_back('{nm, c_IDLE, 0, 0});
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    pulseRst("reset_initial");
    cyc("idle_after_reset", 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_IDLE);

    // Dependency on an ALU writer
    cyc("add_r3", 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, c_IDLE);
`ifdef HAZARD_FORWARD_EN
    cyc("use_r3_fwd", 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_IDLE);
    cyc("ld_r2",      3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, c_IDLE);
    cyc("use_r2_s1",  3'd0, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_STALL);
    cyc("use_r2_go",  3'd0, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_IDLE);
`else
    cyc("use_r3_s1", 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_STALL);
    cyc("use_r3_s2", 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_STALL);
    cyc("use_r3_s3", 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_STALL);
    cyc("use_r3_go", 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_IDLE);
`endif

    // Redirect while a hazard is present: flush only
    cyc("add_r5",       3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, c_IDLE);
`ifdef HAZARD_FORWARD_EN
    cyc("flush_nohz",   3'd5, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, c_FLUSH);
`else
    cyc("flush_over_hz", 3'd5, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, c_FLUSH);
`endif
    cyc("ex_slot_empty", 3'd6, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_IDLE);
    cyc("idle_a",        3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_IDLE);

    // Halt and redirect together: halt discarded
    cyc("halt_with_redir", 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, c_FLUSH);
    cyc("still_running",   3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_IDLE);

    // Stall counter saturation
`ifdef HAZARD_FORWARD_EN
    for (int i = 0; i < 50; i++) begin
      cyc("sat_ld",  3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, c_IDLE);
      cyc("sat_use", 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_STALL);
    end
`else
    for (int i = 0; i < 21847; i++) begin
      cyc("sat_wr", 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, c_IDLE);
      for (int k = 0; k < 3; k++)
        cyc("sat_use", 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_STALL);
    end
`endif
    cyc("sat_hold", 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_IDLE);

    // Reset in the middle of a stall clears slots and counters
    cyc("add_r4",    3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, c_IDLE);
    cyc("use_r4_s1", 3'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_STALL);
    pulseRst("reset_mid_stall");
    cyc("slots_cleared", 3'd4, 1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_IDLE);

    // Halt: permanent, redirect ignored
    cyc("halt_issue", 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, c_IDLE);
    for (int i = 0; i < 12; i++)
      cyc("halted_hold", 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, (i == 5), c_HALT);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
